// File: rtl/dot_clk_sequencer.sv
// Dot-clock sequencer: supervises PLL lock, releases the system reset once lock
// has been stable, then splits the dot clock into the 8 sub-phases of a bus
// cycle and tracks the raster beam position.
//
// Ports:
//   clkDot       - dot clock, all logic on its rising edge
//   reset        - asynchronous active-low reset
//   pllLocked    - PLL lock, asynchronous to clkDot
//   isNtsc       - video standard select (1 = NTSC), quasi-static
//   sysReset_n   - active-low reset for downstream logic, high only in run
//   phi0         - CPU phase clock (low = VIC half, high = CPU half)
//   vicEn/cpuEn  - one-dot enables at the end of the VIC/CPU half-cycles
//   subPhase     - dot within the bus cycle, 0..7
//   cycleX       - bus cycle within the line
//   rasterY      - raster line within the frame
//   newLine      - first dot of every line
//   newFrame     - first dot of every frame
//   isNtscActive - video standard currently in effect
module dot_clk_sequencer #(
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned CYCLES_PAL         = 63,
  parameter int unsigned LINES_PAL          = 312,
  parameter int unsigned CYCLES_NTSC        = 65,
  parameter int unsigned LINES_NTSC         = 263
) (
  input  logic       clkDot,
  input  logic       reset,
  input  logic       pllLocked,
  input  logic       isNtsc,
  output logic       sysReset_n,
  output logic       phi0,
  output logic       vicEn,
  output logic       cpuEn,
  output logic [2:0] subPhase,
  output logic [6:0] cycleX,
  output logic [8:0] rasterY,
  output logic       newLine,
  output logic       newFrame,
  output logic       isNtscActive
);

  localparam int unsigned CntW = (LOCK_STABLE_CYCLES > 2) ? $clog2(LOCK_STABLE_CYCLES) : 1;

  typedef enum logic [1:0] {StWaitLock, StStable, StRun} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            lock_meta_q, lock_s_q;

  logic [2:0] sub_q, sub_d;
  logic [6:0] cyc_q, cyc_d;
  logic [8:0] ras_q, ras_d;
  logic       mode_q, mode_d;
  logic       run_q, run_d;
  logic [6:0] cyc_max;
  logic [8:0] lines_max;
  logic       new_line_d;

  // Two-flop synchronizer for the asynchronous lock input
  always_ff @(posedge clkDot or negedge reset) begin
    if (!reset) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
    end else begin
      lock_meta_q <= pllLocked;
      lock_s_q    <= lock_meta_q;
    end
  end

  always_ff @(posedge clkDot or negedge reset) begin
    if (!reset) begin
      state_q <= StWaitLock;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StWaitLock: begin
        cnt_d = '0;
        if (lock_s_q) state_d = StStable;
      end
      StStable: begin
        if (!lock_s_q) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
          // Leave on the edge where the count reaches LOCK_STABLE_CYCLES-1
          if (cnt_q == CntW'(LOCK_STABLE_CYCLES - 2)) state_d = StRun;
        end
      end
      StRun: begin
        cnt_d = '0;
        if (!lock_s_q) state_d = StWaitLock;
      end
      default: begin
        state_d = StWaitLock;
        cnt_d   = '0;
      end
    endcase
  end

  assign run_d     = (state_d == StRun);
  assign cyc_max   = mode_q ? 7'(CYCLES_NTSC - 1) : 7'(CYCLES_PAL - 1);
  assign lines_max = mode_q ? 9'(LINES_NTSC - 1) : 9'(LINES_PAL - 1);

  // Beam counters; outputs are registered from the next-state values so they
  // line up with the counters on the same edge.
  always_comb begin
    sub_d  = sub_q;
    cyc_d  = cyc_q;
    ras_d  = ras_q;
    mode_d = mode_q;
    if (!run_d) begin
      sub_d = '0;
      cyc_d = '0;
      ras_d = '0;
    end else if (!run_q) begin
      // Entry into run: counters are already zero, only the mode latches
      mode_d = isNtsc;
    end else begin
      sub_d = sub_q + 3'd1;
      if (sub_q == 3'd7) begin
        if (cyc_q == cyc_max) begin
          cyc_d = '0;
          if (ras_q == lines_max) begin
            ras_d  = '0;
            mode_d = isNtsc;
          end else begin
            ras_d = ras_q + 9'd1;
          end
        end else begin
          cyc_d = cyc_q + 7'd1;
        end
      end
    end
  end

  assign new_line_d = run_d && (sub_d == 3'd0) && (cyc_d == 7'd0);

  always_ff @(posedge clkDot or negedge reset) begin
    if (!reset) begin
      sub_q    <= '0;
      cyc_q    <= '0;
      ras_q    <= '0;
      mode_q   <= 1'b0;
      run_q    <= 1'b0;
      phi0     <= 1'b0;
      vicEn    <= 1'b0;
      cpuEn    <= 1'b0;
      newLine  <= 1'b0;
      newFrame <= 1'b0;
    end else begin
      sub_q    <= sub_d;
      cyc_q    <= cyc_d;
      ras_q    <= ras_d;
      mode_q   <= mode_d;
      run_q    <= run_d;
      phi0     <= run_d && sub_d[2];
      vicEn    <= run_d && (sub_d == 3'd3);
      cpuEn    <= run_d && (sub_d == 3'd7);
      newLine  <= new_line_d;
      newFrame <= new_line_d && (ras_d == 9'd0);
    end
  end

  assign sysReset_n   = run_q;
  assign subPhase     = sub_q;
  assign cycleX       = cyc_q;
  assign rasterY      = ras_q;
  assign isNtscActive = mode_q;

endmodule

// File: tb/tb_dot_clk_sequencer.sv
// Directed bench for dot_clk_sequencer with a short lock count and short
// frames (20 PAL lines, 16 NTSC lines) so whole frames fit a small run.
module tb_dot_clk_sequencer;

  localparam int unsigned LockN   = 16;
  localparam int unsigned LinesP  = 20;
  localparam int unsigned LinesN  = 16;
  localparam int unsigned DotsP   = 63 * 8 * LinesP;
  localparam int unsigned DotsN   = 65 * 8 * LinesN;

  logic       clkDot = 1'b0;
  logic       reset = 1'b0;
  logic       pllLocked = 1'b0;
  logic       isNtsc = 1'b0;
  logic       sysReset_n, phi0, vicEn, cpuEn, newLine, newFrame, isNtscActive;
  logic [2:0] subPhase;
  logic [6:0] cycleX;
  logic [8:0] rasterY;

  int n_vec = 0;
  int n_mis = 0;

  dot_clk_sequencer #(
    .LOCK_STABLE_CYCLES(LockN),
    .CYCLES_PAL        (63),
    .LINES_PAL         (LinesP),
    .CYCLES_NTSC       (65),
    .LINES_NTSC        (LinesN)
  ) dut (
    .clkDot      (clkDot),
    .reset       (reset),
    .pllLocked   (pllLocked),
    .isNtsc      (isNtsc),
    .sysReset_n  (sysReset_n),
    .phi0        (phi0),
    .vicEn       (vicEn),
    .cpuEn       (cpuEn),
    .subPhase    (subPhase),
    .cycleX      (cycleX),
    .rasterY     (rasterY),
    .newLine     (newLine),
    .newFrame    (newFrame),
    .isNtscActive(isNtscActive)
  );

  always #5 clkDot = ~clkDot;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clkDot);
    #1;
  endtask

  // Edges from now until sysReset_n is seen high; 0 if it never rises
  task automatic count_to_run(output int n);
    n = 0;
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (sysReset_n === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, t, last_line, max_cyc, max_ras, prev_ras, early;
    bit found;

    // Reset state
    repeat (3) tick();
    check("rst sysReset_n", 32'(sysReset_n), 0);
    check("rst phi0", 32'(phi0), 0);
    check("rst vicEn", 32'(vicEn), 0);
    check("rst cpuEn", 32'(cpuEn), 0);
    check("rst subPhase", 32'(subPhase), 0);
    check("rst cycleX", 32'(cycleX), 0);
    check("rst rasterY", 32'(rasterY), 0);
    check("rst newLine", 32'(newLine), 0);
    check("rst newFrame", 32'(newFrame), 0);
    check("rst isNtscActive", 32'(isNtscActive), 0);

    // Lock-up: lock arrives 5 cycles after reset release
    reset = 1'b1;
    repeat (5) tick();
    pllLocked = 1'b1;
    count_to_run(n);
    check("lockup edges", n, 18);
    check("first run newFrame", 32'(newFrame), 1);
    check("first run newLine", 32'(newLine), 1);
    check("first run subPhase", 32'(subPhase), 0);
    check("first run phi0", 32'(phi0), 0);

    // Asynchronous reset takes effect mid-cycle
    #2 reset = 1'b0;
    #1;
    check("async rst sysReset_n", 32'(sysReset_n), 0);
    check("async rst newFrame", 32'(newFrame), 0);
    pllLocked = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    repeat (2) tick();

    // Lock glitch at stable count 10 restarts the whole count
    pllLocked = 1'b1;
    repeat (13) tick();
    pllLocked = 1'b0;
    repeat (3) tick();
    pllLocked = 1'b1;
    count_to_run(n);
    check("glitch relock edges", n, 18);

    // Phase pattern over 24 dots from the first run cycle
    for (int i = 0; i < 24; i++) begin
      logic [12:0] exp_v;
      if (i > 0) tick();
      exp_v = {7'(i / 8), (i % 8) >= 4, (i % 8) == 3, (i % 8) == 7, 3'(i % 8)};
      check($sformatf("phase dot %0d", i), {19'd0, cycleX, phi0, vicEn, cpuEn, subPhase},
            {19'd0, exp_v});
    end

    // PAL frame, with isNtsc raised mid-frame
    t = 23; last_line = 0; max_cyc = 0; prev_ras = 0; early = 0;
    for (int i = 0; i < 2 * DotsP; i++) begin
      prev_ras = rasterY;
      tick();
      t++;
      if (cycleX > max_cyc) max_cyc = cycleX;
      if (rasterY == 10 && !isNtsc) isNtsc = 1'b1;
      if (newLine) begin
        check("pal line gap", t - last_line, 504);
        last_line = t;
      end
      if (newFrame) break;
      if (isNtscActive !== 1'b0) early++;
    end
    check("pal frame dots", t, DotsP);
    check("pal last line", prev_ras, LinesP - 1);
    check("pal max cycleX", max_cyc, 62);
    check("ntsc before wrap", early, 0);
    check("ntsc after wrap", 32'(isNtscActive), 1);
    check("wrap cycleX rasterY", {16'd0, 7'(cycleX), rasterY}, 0);

    // NTSC frame
    t = 0; last_line = 0; max_cyc = 0; max_ras = 0;
    for (int i = 0; i < 2 * DotsN; i++) begin
      tick();
      t++;
      if (cycleX > max_cyc) max_cyc = cycleX;
      if (rasterY > max_ras) max_ras = rasterY;
      if (newLine) begin
        check("ntsc line gap", t - last_line, 520);
        last_line = t;
      end
      if (newFrame) break;
    end
    check("ntsc frame dots", t, DotsN);
    check("ntsc max cycleX", max_cyc, 64);
    check("ntsc max rasterY", max_ras, LinesN - 1);

    // Mid-frame lock loss at cycleX 30, rasterY 10
    found = 1'b0;
    for (int i = 0; i < 2 * DotsN; i++) begin
      tick();
      if (cycleX == 30 && rasterY == 10) begin
        found = 1'b1;
        break;
      end
    end
    check("reach x30 y10", 32'(found), 1);
    pllLocked = 1'b0;
    repeat (2) tick();
    check("loss +2 sysReset_n", 32'(sysReset_n), 1);
    tick();
    check("loss +3 sysReset_n", 32'(sysReset_n), 0);
    check("loss +3 counters", {13'd0, subPhase, cycleX, rasterY}, 0);
    check("loss +3 flags", {27'd0, newLine, newFrame, phi0, vicEn, cpuEn}, 0);

    // Relock with NTSC deselected: mode latches on run entry
    isNtsc = 1'b0;
    repeat (4) tick();
    pllLocked = 1'b1;
    count_to_run(n);
    check("relock edges", n, 18);
    check("relock newFrame", 32'(newFrame), 1);
    check("relock isNtscActive", 32'(isNtscActive), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
